// File: rtl/note_recorder.sv
// Records the played note stream into one of NUM_SLOTS memory slots, one word per tick,
// and closes each recording with a single END_MARK word.
module note_recorder #(
  parameter int unsigned SLOT_DEPTH = 3072,
  parameter int unsigned NUM_SLOTS  = 5,
  parameter logic [26:0] END_MARK   = 27'h7FFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  slot,
  input  logic [26:0] key,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [26:0] mem_wdata,
  output logic        busy,
  output logic        full,
  output logic [11:0] rec_len
);

  localparam logic [13:0] Depth      = 14'(SLOT_DEPTH);
  localparam logic [13:0] LastOffset = 14'(SLOT_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRecord, StTerm} state_e;

  state_e      state_q, state_d;
  logic [13:0] base_q, base_d;
  logic [13:0] offset_q, offset_d;
  logic [11:0] len_q, len_d;
  logic        full_q, full_d;
  logic        pend_q, pend_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [26:0] wdata_q, wdata_d;

  logic [13:0] slot_base;
  logic        slot_ok;
  logic [26:0] note;
  logic [13:0] cur_addr;

  assign slot_base = 14'(slot) * Depth;
  assign slot_ok   = 32'(slot) < NUM_SLOTS;
  // Keep the marker unique within the note stream.
  assign note      = (key == END_MARK) ? END_MARK - 27'd1 : key;
  assign cur_addr  = base_q + offset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      offset_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      pend_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      full_q   <= full_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    len_d    = len_q;
    full_d   = full_q;
    pend_d   = pend_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start && slot_ok) begin
          base_d   = slot_base;
          offset_d = '0;
          len_d    = '0;
          full_d   = 1'b0;
          pend_d   = 1'b0;
          addr_d   = slot_base;
          state_d  = StArmed;
        end
      end
      StArmed, StRecord: begin
        // pend_q: a note went out last clk and the marker must follow on its own clk.
        if (pend_q) begin
          we_d    = 1'b1;
          addr_d  = cur_addr;
          wdata_d = END_MARK;
          pend_d  = 1'b0;
          state_d = StTerm;
        end else if (tick) begin
          we_d     = 1'b1;
          addr_d   = cur_addr;
          wdata_d  = note;
          offset_d = offset_q + 14'd1;
          len_d    = len_q + 12'd1;
          state_d  = StRecord;
          if (offset_q + 14'd1 == LastOffset) begin
            full_d = 1'b1;
            pend_d = 1'b1;
          end else if (stop) begin
            pend_d = 1'b1;
          end
        end else if (stop) begin
          we_d    = 1'b1;
          addr_d  = cur_addr;
          wdata_d = END_MARK;
          state_d = StTerm;
        end
      end
      StTerm: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign full      = full_q;
  assign rec_len   = len_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: a default instance and a 4-word-slot instance share stimulus and are
// compared every clk against a per-recording reference model, plus directed scenario checks.
module tb_note_recorder;

  localparam logic [26:0] Mark = 27'h7FFFFFF;

  logic        clk, reset, tick, start, stop;
  logic [2:0]  slot;
  logic [26:0] key;
  logic        dut_we    [2];
  logic [13:0] dut_addr  [2];
  logic [26:0] dut_wdata [2];
  logic        dut_busy  [2];
  logic        dut_full  [2];
  logic [11:0] dut_len   [2];

  note_recorder u_big (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .slot(slot), .key(key),
    .mem_we(dut_we[0]), .mem_addr(dut_addr[0]), .mem_wdata(dut_wdata[0]),
    .busy(dut_busy[0]), .full(dut_full[0]), .rec_len(dut_len[0])
  );

  note_recorder #(.SLOT_DEPTH(4), .NUM_SLOTS(4), .END_MARK(Mark)) u_small (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .slot(slot), .key(key),
    .mem_we(dut_we[1]), .mem_addr(dut_addr[1]), .mem_wdata(dut_wdata[1]),
    .busy(dut_busy[1]), .full(dut_full[1]), .rec_len(dut_len[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a recording is a session that is either taking notes, owes its marker,
  // or is in its marker clk.
  int unsigned m_depth [2] = '{3072, 4};
  int unsigned m_slots [2] = '{5, 4};
  int          m_phase [2] = '{0, 0};  // 0 idle, 1 taking notes, 2 marker owed, 3 marker clk
  int unsigned m_base  [2] = '{0, 0};
  int unsigned m_count [2] = '{0, 0};
  int unsigned m_addr  [2] = '{0, 0};
  bit [26:0]   m_data  [2] = '{0, 0};
  bit          m_full  [2] = '{0, 0};
  bit          m_we    [2] = '{0, 0};

  int unsigned log_addr [2][$];
  bit [26:0]   log_data [2][$];

  task automatic put_marker(input int i);
    m_we[i]   = 1'b1;
    m_addr[i] = m_base[i] + m_count[i];
    m_data[i] = Mark;
  endtask

  task automatic model_step(input int i);
    m_we[i] = 1'b0;
    if (reset) begin
      m_phase[i] = 0; m_base[i] = 0; m_count[i] = 0; m_full[i] = 0;
      m_addr[i] = 0; m_data[i] = '0;
    end else begin
      case (m_phase[i])
        0: if (start && slot < m_slots[i]) begin
          m_base[i]  = slot * m_depth[i];
          m_count[i] = 0;
          m_full[i]  = 0;
          m_addr[i]  = m_base[i];
          m_phase[i] = 1;
        end
        1: if (tick) begin
          m_we[i]   = 1'b1;
          m_addr[i] = m_base[i] + m_count[i];
          m_data[i] = (key == Mark) ? Mark - 1 : key;
          m_count[i]++;
          if (m_count[i] == m_depth[i] - 1) begin
            m_full[i]  = 1;
            m_phase[i] = 2;
          end else if (stop) m_phase[i] = 2;
        end else if (stop) begin
          put_marker(i);
          m_phase[i] = 3;
        end
        2: begin put_marker(i); m_phase[i] = 3; end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d mem_we", i), 32'(dut_we[i]), 32'(m_we[i]));
      check($sformatf("d%0d busy", i), 32'(dut_busy[i]), 32'(m_phase[i] != 0));
      check($sformatf("d%0d full", i), 32'(dut_full[i]), 32'(m_full[i]));
      check($sformatf("d%0d rec_len", i), 32'(dut_len[i]), m_count[i] & 32'hFFF);
      if (m_we[i] || reset) begin
        check($sformatf("d%0d mem_addr", i), 32'(dut_addr[i]), m_addr[i]);
        check($sformatf("d%0d mem_wdata", i), 32'(dut_wdata[i]), 32'(m_data[i]));
      end
      if (dut_we[i] === 1'b1) begin
        log_addr[i].push_back(32'(dut_addr[i]));
        log_data[i].push_back(dut_wdata[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    tick = 0; start = 0; stop = 0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      log_addr[i].delete();
      log_data[i].delete();
    end
  endtask

  task automatic pulse_start(input logic [2:0] s);
    slot = s; start = 1; cycle(); start = 0;
  endtask

  task automatic pulse_tick(input logic [26:0] k);
    key = k; tick = 1; cycle(); tick = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; cycle(); stop = 0;
  endtask

  task automatic check_log(input string tag, input int i, input int unsigned a[$],
                           input bit [26:0] d[$]);
    check({tag, " writes"}, 32'(log_addr[i].size()), 32'(a.size()));
    for (int k = 0; k < a.size() && k < log_addr[i].size(); k++) begin
      check($sformatf("%s addr%0d", tag, k), log_addr[i][k], a[k]);
      check($sformatf("%s data%0d", tag, k), 32'(log_data[i][k]), 32'(d[k]));
    end
  endtask

  initial begin
    reset = 1; tick = 0; start = 0; stop = 0; slot = 0; key = 0;
    cycle();
    for (int i = 0; i < 2; i++) begin
      check("reset addr", 32'(dut_addr[i]), 32'd0);
      check("reset busy", 32'(dut_busy[i]), 32'd0);
    end
    reset = 0;
    idle(2);

    // Two notes into slot 2, then stop.
    clear_logs();
    pulse_start(3'd2); idle(1);
    pulse_tick(27'd5); idle(2);
    pulse_tick(27'd9); idle(1);
    pulse_stop(); idle(3);
    check_log("slot2", 0, '{6144, 6145, 6146}, '{27'd5, 27'd9, Mark});
    check("slot2 rec_len", 32'(dut_len[0]), 32'd2);
    check("slot2 full", 32'(dut_full[0]), 32'd0);
    check("slot2 busy", 32'(dut_busy[0]), 32'd0);

    // Small slot fills after three notes; later ticks are ignored.
    clear_logs();
    pulse_start(3'd0);
    for (int k = 1; k <= 5; k++) begin
      pulse_tick(27'(k)); idle(1);
    end
    check_log("fill", 1, '{0, 1, 2, 3}, '{27'd1, 27'd2, 27'd3, Mark});
    check("fill full", 32'(dut_full[1]), 32'd1);
    check("fill rec_len", 32'(dut_len[1]), 32'd3);
    pulse_stop(); idle(3);

    // Tick coincident with stop.
    clear_logs();
    pulse_start(3'd1);
    pulse_tick(27'h111);
    key = 27'h222; tick = 1; stop = 1; cycle(); tick = 0; stop = 0;
    idle(3);
    check_log("tickstop", 0, '{3072, 3073, 3074}, '{27'h111, 27'h222, Mark});

    // Out-of-range slot, then start while busy.
    clear_logs();
    pulse_start(3'd5);
    check("bad slot busy", 32'(dut_busy[0]), 32'd0);
    idle(1);
    pulse_start(3'd0);
    pulse_start(3'd1);
    pulse_tick(27'h33); pulse_stop(); idle(3);
    check_log("busy start", 0, '{0, 1}, '{27'h33, Mark});

    // Note equal to the marker is substituted.
    pulse_start(3'd3);
    pulse_tick(Mark);
    check("mark subst", 32'(dut_wdata[0]), 32'h7FFFFFE);
    pulse_stop(); idle(3);

    // Reset mid-recording: no marker, then a fresh recording works.
    clear_logs();
    pulse_start(3'd1);
    pulse_tick(27'h44); pulse_tick(27'h55);
    reset = 1; cycle(); reset = 0;
    check("rst len", 32'(dut_len[0]), 32'd0);
    check("rst wdata", 32'(dut_wdata[0]), 32'd0);
    idle(3);
    check("rst no marker", 32'(log_addr[0].size()), 32'd2);
    clear_logs();
    pulse_start(3'd0);
    pulse_tick(27'h66); pulse_stop(); idle(3);
    check_log("after rst", 0, '{0, 1}, '{27'h66, Mark});

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      slot  = 3'($urandom_range(0, 7));
      key   = ($urandom_range(0, 9) == 0) ? Mark : 27'($urandom);
      cycle();
    end
    reset = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
